// File: rtl/nw_pkg.sv
// Shared Needleman-Wunsch definitions: direction/move codes, traceback states
// and the row-major matrix address helper used by the fill and traceback paths.
`timescale 1ns/1ps
package nw_pkg;

   localparam logic [1:0] DIR_DIAG = 2'b00;
   localparam logic [1:0] DIR_UP   = 2'b01;
   localparam logic [1:0] DIR_LEFT = 2'b10;
   localparam logic [1:0] DIR_ERR  = 2'b11;

   typedef enum logic [2:0] {
      T_IDLE,
      T_ADDR,
      T_STEP,
      T_EDGE,
      T_DONE
   } tb_state_t;

   // Row-major address of cell (i,j) in an (n+1)x(n+1) matrix.
   function automatic int unsigned mat_addr(input int unsigned i,
                                            input int unsigned j,
                                            input int unsigned n);
      return i * (n + 1) + j;
   endfunction

endpackage

// File: rtl/nw_tb_addr_gen.sv
// Traceback cursor: holds the current (i,j) cell, steps it toward the origin
// and presents the matching direction-memory address combinationally.
`timescale 1ns/1ps
module nw_tb_addr_gen
   import nw_pkg::*;
#(
   parameter int N      = 8,
   parameter int IDX_W  = $clog2(N + 1),
   parameter int ADDR_W = $clog2((N + 1) * (N + 1))
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              dec_i,
   input  logic              dec_j,
   output logic [IDX_W-1:0]  i,
   output logic [IDX_W-1:0]  j,
   output logic [ADDR_W-1:0] addr
);

   logic [IDX_W-1:0] i_reg;
   logic [IDX_W-1:0] j_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         i_reg <= '0;
         j_reg <= '0;
      end else if (load) begin
         i_reg <= IDX_W'(N);
         j_reg <= IDX_W'(N);
      end else begin
         if (dec_i) i_reg <= i_reg - IDX_W'(1);
         if (dec_j) j_reg <= j_reg - IDX_W'(1);
      end
   end

   assign i    = i_reg;
   assign j    = j_reg;
   assign addr = ADDR_W'(mat_addr(32'(i_reg), 32'(j_reg), 32'(N)));

endmodule

// File: rtl/nw_traceback.sv
// Needleman-Wunsch traceback: walks the direction matrix from (N,N) to (0,0).
// Define NW_TB_ERR_CHECK_EN to add tb_err and stop the walk on direction code 11.
`timescale 1ns/1ps
module nw_traceback
   import nw_pkg::*;
#(
   parameter int N      = 8,
   parameter int IDX_W  = $clog2(N + 1),
   parameter int ADDR_W = $clog2((N + 1) * (N + 1))
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en_traceB,
   output logic              dir_rd,
   output logic [ADDR_W-1:0] dir_addr,
   input  logic [1:0]        dir_data,
   output logic              align_valid,
   output logic [1:0]        align_move,
   output logic [IDX_W-1:0]  align_i,
   output logic [IDX_W-1:0]  align_j,
   output logic              end_traceB
`ifdef NW_TB_ERR_CHECK_EN
   ,
   output logic              tb_err
`endif
);

`ifdef NW_TB_ERR_CHECK_EN
   localparam bit ERR_CHECK = 1'b1;
   logic err_reg;
   assign tb_err = err_reg;
`else
   localparam bit ERR_CHECK = 1'b0;
`endif

   tb_state_t         state_reg;
   logic [IDX_W-1:0]  i_cur, j_cur, i_next, j_next;
   logic [ADDR_W-1:0] cell_addr, addr_hold_reg;
   logic              load, dec_i, dec_j, step_err;

   nw_tb_addr_gen #(.N(N), .IDX_W(IDX_W), .ADDR_W(ADDR_W)) u_addr_gen (
      .clk   (clk),
      .rst   (rst),
      .load  (load),
      .dec_i (dec_i),
      .dec_j (dec_j),
      .i     (i_cur),
      .j     (j_cur),
      .addr  (cell_addr)
   );

   assign step_err = ERR_CHECK && (state_reg == T_STEP) && (dir_data == DIR_ERR);

   // Moves are shown in the cycle they are decided; an aborted walk shows none.
   always_comb begin
      load        = 1'b0;
      dec_i       = 1'b0;
      dec_j       = 1'b0;
      align_valid = 1'b0;
      align_move  = DIR_DIAG;
      case (state_reg)
         T_IDLE: load = en_traceB;
         T_STEP: if (en_traceB && !step_err) begin
            align_valid = 1'b1;
            align_move  = (dir_data == DIR_ERR) ? DIR_DIAG : dir_data;
            dec_i       = (align_move != DIR_LEFT);
            dec_j       = (align_move != DIR_UP);
         end
         T_EDGE: if (en_traceB) begin
            align_valid = 1'b1;
            align_move  = (i_cur == '0) ? DIR_LEFT : DIR_UP;
            dec_i       = (i_cur != '0);
            dec_j       = (i_cur == '0);
         end
         default: ;
      endcase
   end

   assign i_next = dec_i ? i_cur - IDX_W'(1) : i_cur;
   assign j_next = dec_j ? j_cur - IDX_W'(1) : j_cur;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= T_IDLE;
         addr_hold_reg <= '0;
`ifdef NW_TB_ERR_CHECK_EN
         err_reg       <= 1'b0;
`endif
      end else begin
         if (state_reg == T_ADDR) addr_hold_reg <= cell_addr;
         case (state_reg)
            T_IDLE: if (en_traceB) begin
`ifdef NW_TB_ERR_CHECK_EN
               err_reg   <= 1'b0;
`endif
               state_reg <= (N == 0) ? T_DONE : T_ADDR;
            end
            T_ADDR: state_reg <= en_traceB ? T_STEP : T_IDLE;
            T_STEP, T_EDGE: begin
               if (!en_traceB) begin
                  state_reg <= T_IDLE;
               end else if (step_err) begin
`ifdef NW_TB_ERR_CHECK_EN
                  err_reg   <= 1'b1;
`endif
                  state_reg <= T_DONE;
               end else if (i_next == '0 && j_next == '0) begin
                  state_reg <= T_DONE;
               end else if (i_next == '0 || j_next == '0) begin
                  state_reg <= T_EDGE;
               end else begin
                  state_reg <= T_ADDR;
               end
            end
            T_DONE: if (!en_traceB) state_reg <= T_IDLE;
            default: state_reg <= T_IDLE;
         endcase
      end
   end

   assign dir_rd     = (state_reg == T_ADDR);
   assign dir_addr   = dir_rd ? cell_addr : addr_hold_reg;
   assign end_traceB = (state_reg == T_DONE);
   assign align_i    = i_cur;
   assign align_j    = j_cur;

endmodule

// File: tb/tb_nw_traceback.sv
// Directed bench for nw_traceback: N=4 and N=3 instances, each with a
// 1-cycle-latency direction RAM model; moves are logged with walk-relative cycle.
`timescale 1ns/1ps
module tb_nw_traceback;

   localparam int DIAG = 0, UP = 1, LEFT = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   // N=4 instance
   logic       en4 = 1'b0, rd4, v4, end4;
   logic [4:0] addr4;
   logic [1:0] dout4 = 2'b00, move4;
   logic [2:0] i4, j4;
   logic [1:0] mem4 [25];
   // N=3 instance
   logic       en3 = 1'b0, rd3, v3, end3;
   logic [3:0] addr3;
   logic [1:0] dout3 = 2'b00, move3;
   logic [1:0] i3, j3;
   logic [1:0] mem3 [16];
`ifdef NW_TB_ERR_CHECK_EN
   logic err4, err3;
`endif

   nw_traceback #(.N(4)) dut4 (
      .clk(clk), .rst(rst), .en_traceB(en4), .dir_rd(rd4), .dir_addr(addr4),
      .dir_data(dout4), .align_valid(v4), .align_move(move4), .align_i(i4),
      .align_j(j4), .end_traceB(end4)
`ifdef NW_TB_ERR_CHECK_EN
      , .tb_err(err4)
`endif
   );

   nw_traceback #(.N(3)) dut3 (
      .clk(clk), .rst(rst), .en_traceB(en3), .dir_rd(rd3), .dir_addr(addr3),
      .dir_data(dout3), .align_valid(v3), .align_move(move3), .align_i(i3),
      .align_j(j3), .end_traceB(end3)
`ifdef NW_TB_ERR_CHECK_EN
      , .tb_err(err3)
`endif
   );

   always @(posedge clk) begin
      if (rd4) dout4 <= mem4[addr4];
      if (rd3) dout3 <= mem3[addr3];
   end

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   function automatic int mv(input int m, input int i, input int j, input int t);
      return (m << 24) | (i << 16) | (j << 8) | t;
   endfunction

   int q4[$], ra4[$], q3[$], ra3[$], exp_q[$];
   int t0_4 = 0, t0_3 = 0, end_t4 = -1, end_t3 = -1;

   always @(negedge clk) begin
      if (v4) begin
         q4.push_back(mv(int'(move4), int'(i4), int'(j4), cyc - t0_4));
         $display("dut4 t=%0d move=%0d i=%0d j=%0d", cyc - t0_4, move4, i4, j4);
         chk("range4", int'(i4 <= 3'd4 && j4 <= 3'd4), 1);
      end
      if (rd4) ra4.push_back(int'(addr4));
      if (end4 && end_t4 < 0) end_t4 = cyc - t0_4;
      if (v3) begin
         q3.push_back(mv(int'(move3), int'(i3), int'(j3), cyc - t0_3));
         $display("dut3 t=%0d move=%0d i=%0d j=%0d", cyc - t0_3, move3, i3, j3);
      end
      if (rd3) ra3.push_back(int'(addr3));
      if (end3 && end_t3 < 0) end_t3 = cyc - t0_3;
   end

   task automatic em(input int m, input int i, input int j, input int t);
      exp_q.push_back(mv(m, i, j, t));
   endtask

   task automatic cmp_q(input string tag, input int got[$]);
      chk({tag, "_n"}, got.size(), exp_q.size());
      foreach (exp_q[k])
         chk($sformatf("%s_%0d", tag, k), (k < got.size()) ? got[k] : -1, exp_q[k]);
      exp_q.delete();
   endtask

   task automatic fill4(input int code);
      for (int a = 0; a < 25; a++) mem4[a] = 2'(code);
   endtask

   task automatic start4();
      @(posedge clk); #1;
      q4.delete(); ra4.delete(); end_t4 = -1; t0_4 = cyc; en4 = 1'b1;
   endtask

   task automatic start3();
      @(posedge clk); #1;
      q3.delete(); ra3.delete(); end_t3 = -1; t0_3 = cyc; en3 = 1'b1;
   endtask

   task automatic wait_end4(input string tag, input int exp_t);
      for (int k = 0; k < 40 && end_t4 < 0; k++) @(negedge clk);
      chk({tag, "_end_t"}, end_t4, exp_t);
   endtask

   task automatic stop4(input string tag);
      @(posedge clk); #1; en4 = 1'b0;
      repeat (2) @(negedge clk);
      chk({tag, "_end_low"}, int'(end4), 0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_rd", int'(rd4), 0);
      chk("rst_addr", int'(addr4), 0);
      chk("rst_valid", int'(v4), 0);
      chk("rst_ij", int'({i4, j4, move4}), 0);
      chk("rst_end", int'(end4), 0);
      rst = 1'b0;

      // all DIAG: four interior moves, reads at 24,18,12,6
      fill4(DIAG);
      start4();
      wait_end4("t1", 9);
      em(DIAG,4,4,2); em(DIAG,3,3,4); em(DIAG,2,2,6); em(DIAG,1,1,8);
      cmp_q("t1_mv", q4);
      exp_q = '{24, 18, 12, 6};
      cmp_q("t1_addr", ra4);
      stop4("t1");

      // UP at the corner, then DIAG to (0,1), one edge LEFT
      fill4(DIAG); mem4[24] = 2'(UP);
      start4();
      wait_end4("t2", 10);
      em(UP,4,4,2); em(DIAG,3,4,4); em(DIAG,2,3,6); em(DIAG,1,2,8); em(LEFT,0,1,9);
      cmp_q("t2_mv", q4);
      exp_q = '{24, 19, 13, 7};
      cmp_q("t2_addr", ra4);
      stop4("t2");

      // N=3 all LEFT: three read moves then three edge UPs
      for (int a = 0; a < 16; a++) mem3[a] = 2'(LEFT);
      start3();
      for (int k = 0; k < 40 && end_t3 < 0; k++) @(negedge clk);
      chk("t3_end_t", end_t3, 10);
      em(LEFT,3,3,2); em(LEFT,3,2,4); em(LEFT,3,1,6); em(UP,3,0,7); em(UP,2,0,8); em(UP,1,0,9);
      cmp_q("t3_mv", q3);
      exp_q = '{15, 14, 13};
      cmp_q("t3_addr", ra3);
`ifdef NW_TB_ERR_CHECK_EN
      chk("t3_err", int'(err3), 0);
`endif
      @(posedge clk); #1; en3 = 1'b0;

      // abort after the second move, then restart
      fill4(DIAG);
      start4();
      repeat (5) @(posedge clk);
      #1; en4 = 1'b0;
      chk("t4_moves_before", q4.size(), 2);
      @(posedge clk); @(negedge clk);
      chk("t4_idle_rd", int'(rd4), 0);
      repeat (8) @(negedge clk);
      chk("t4_moves_after", q4.size(), 2);
      chk("t4_no_end", end_t4, -1);
      start4();
      wait_end4("t4r", 9);
      em(DIAG,4,4,2); em(DIAG,3,3,4); em(DIAG,2,2,6); em(DIAG,1,1,8);
      cmp_q("t4r_mv", q4);
      stop4("t4r");

      // reset mid-walk in T_ADDR at cycle 5
      fill4(DIAG);
      start4();
      repeat (5) @(posedge clk);
      #1;
      chk("t5_pre_addr", int'(addr4), 12);
      rst = 1'b1; en4 = 1'b0;
      #1;
      chk("t5_rd", int'(rd4), 0);
      chk("t5_addr", int'(addr4), 0);
      chk("t5_ij", int'({i4, j4}), 0);
      chk("t5_valid_end", int'({v4, end4}), 0);
      @(negedge clk); rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("t5_idle", int'({rd4, v4, end4}), 0);
      start4();
      wait_end4("t5r", 9);
      chk("t5r_n", q4.size(), 4);
      chk("t5r_first", (q4.size() > 0) ? q4[0] : -1, mv(DIAG,4,4,2));
      stop4("t5r");

      // direction code 11 at (3,3)
      fill4(DIAG); mem4[18] = 2'b11;
      start4();
`ifdef NW_TB_ERR_CHECK_EN
      wait_end4("t6", 5);
      em(DIAG,4,4,2);
      cmp_q("t6_mv", q4);
      chk("t6_err", int'(err4), 1);
      stop4("t6");
      chk("t6_err_sticky", int'(err4), 1);
      fill4(DIAG);
      start4();
      @(posedge clk); @(negedge clk);
      chk("t6_err_clr", int'(err4), 0);
      wait_end4("t6r", 9);
      stop4("t6r");
`else
      wait_end4("t6", 9);
      em(DIAG,4,4,2); em(DIAG,3,3,4); em(DIAG,2,2,6); em(DIAG,1,1,8);
      cmp_q("t6_mv", q4);
      stop4("t6");
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
